// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU FSM states
// and a small helper that decodes access width from funct3.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2
    } lsu_width_t;

    // funct3[1:0]: 00 byte, 01 half, anything else (10, 11) is a word access.
    function automatic lsu_width_t f3_width(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return W_BYTE;
            2'b01:   return W_HALF;
            default: return W_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks the byte/half lane selected by the
// low address bits and sign- or zero-extends it (funct3[2]=1 means unsigned).
// Halves use addr[1] only; words ignore the low bits entirely.
module lsu_load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select and extension.
    always_comb begin
        byte_sel    = rdata_i[7:0];
        half_sel    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        load_data_o = rdata_i;
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        case (f3_width(funct3_i))
            W_BYTE:  load_data_o = funct3_i[2] ? {24'b0, byte_sel}
                                               : {{24{byte_sel[7]}}, byte_sel};
            W_HALF:  load_data_o = funct3_i[2] ? {16'b0, half_sel}
                                               : {{16{half_sel[15]}}, half_sel};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: takes the ALU result as effective address, performs one
// byte/half/word access over dmem req/ack, and stalls the core via busy.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses
// complete immediately with misalign=1 and never touch memory).
//
// Memory handshake: dmem_req is asserted in REQ and held, together with
// constant dmem_addr/dmem_we/dmem_be/dmem_wdata, until the cycle in which
// dmem_ack=1; that cycle completes the transfer (dmem_rdata valid for
// loads) and dmem_req drops at the following edge. Ack may come in the
// first REQ cycle.
module lsu
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] load_data,
    output logic            misalign,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output lsu_state_t      state_dbg
);

    lsu_state_t      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic            misalign_q, misalign_d;

    lsu_width_t      width;
    logic            is_mem;
    logic            mis;
    logic [3:0]      be_new;
    logic [XLEN-1:0] wdata_new;
    logic [31:0]     aligned;

    lsu_load_align u_align (
        .rdata_i     (dmem_rdata),
        .addr_lo_i   (addr_lo_q),
        .funct3_i    (f3_q),
        .load_data_o (aligned)
    );

    // Decode the incoming request: width, misalignment, lanes and store data.
    always_comb begin
        width     = f3_width(funct3);
        is_mem    = mem_read | mem_write;
        mis       = 1'b0;
        be_new    = 4'b1111;
        wdata_new = store_data;
`ifdef MISALIGN_TRAP_EN
        case (width)
            W_HALF:  mis = alu_result[0];
            W_WORD:  mis = |alu_result[1:0];
            default: mis = 1'b0;
        endcase
`else
        mis = 1'b0;
`endif
        case (width)
            W_BYTE: begin
                be_new    = 4'b0001 << alu_result[1:0];
                wdata_new = {4{store_data[7:0]}};
            end
            W_HALF: begin
                be_new    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = store_data;
            end
        endcase
    end

    // FSM next state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_lo_d   = addr_lo_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        misalign_d  = misalign_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_mem && !mis) begin
                        state_d    = REQ;
                        we_d       = mem_write;
                        f3_d       = funct3;
                        addr_lo_d  = alu_result[1:0];
                        addr_d     = {alu_result[XLEN-1:2], 2'b00};
                        be_d       = be_new;
                        wdata_d    = wdata_new;
                        misalign_d = 1'b0;
                    end else begin
                        // No-op or trapped misaligned access: finish without memory.
                        state_d    = DONE;
                        misalign_d = is_mem & mis;
                    end
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    state_d = DONE;
                    if (!we_q) begin
                        load_data_d = aligned;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                misalign_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_lo_q   <= 2'b00;
            addr_q      <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            load_data_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_lo_q   <= addr_lo_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            misalign_q  <= misalign_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = (state_q == REQ) & we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign load_data  = load_data_q;
    assign misalign   = misalign_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed vectors plus randomized ops, with a
// queue-based scoreboard fed by the driver and drained by a monitor.
module tb_lsu;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misalign;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    lsu_state_t  state_dbg;

    lsu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .alu_result (alu_result),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misalign   (misalign),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic        chk_wdata;
        logic [31:0] wdata;
        logic [7:0]  cycles;
    } req_exp_t;

    req_exp_t    req_q[$];
    logic [32:0] exp_q[$];      // {misalign, load_data}
    logic [31:0] model_ld;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int width_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit mis_of(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        return (addr % width_of(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int lane_of(input logic [2:0] f3, input logic [31:0] addr);
        int w;
        w = width_of(f3);
        if (w == 4) return 0;
        return ((addr % 4) / w) * w;
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v;
        v = ((32'd1 << width_of(f3)) - 32'd1) << lane_of(f3, addr);
        return v[3:0];
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] sd);
        case (width_of(f3))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] load_of(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rd);
        int          w;
        logic [31:0] v;
        logic [31:0] span;
        w = width_of(f3);
        v = rd >> (8 * lane_of(f3, addr));
        if (w < 4) begin
            span = 32'd1 << (8 * w);
            v    = v % span;
            if (f3 < 3'd4 && v >= span / 2) v = v - span;
        end
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic garbage();
        start      = 1'($urandom_range(0, 1));
        mem_read   = 1'($urandom_range(0, 1));
        mem_write  = 1'($urandom_range(0, 1));
        funct3     = 3'($urandom_range(0, 7));
        alu_result = $urandom;
        store_data = $urandom;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        model_ld = 32'h0;
    endtask

    // Called at posedge+1 with the DUT idle.
    task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rdata, input int waits);
        bit       is_mem, mis, has_req;
        int       cyc, exp_lat;
        req_exp_t r;
        is_mem  = rd | wr;
        mis     = is_mem && mis_of(f3, addr);
        has_req = is_mem && !mis;
        if (has_req) begin
            r.addr      = addr & 32'hFFFF_FFFC;
            r.be        = be_of(f3, addr);
            r.we        = wr;
            r.chk_wdata = wr;
            r.wdata     = wdata_of(f3, sd);
            r.cycles    = 8'(waits + 1);
            req_q.push_back(r);
            if (!wr) model_ld = load_of(f3, addr, rdata);
        end
        exp_q.push_back({mis, model_ld});
        exp_lat = has_req ? waits + 2 : 1;

        start      = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        alu_result = addr;
        store_data = sd;
        @(posedge clk); #1;
        cyc   = 1;
        start = 1'b0;
        if (has_req) begin
            repeat (waits) begin
                garbage();
                @(posedge clk); #1;
                cyc++;
            end
            garbage();
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
            @(posedge clk); #1;
            cyc++;
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            start      = 1'b0;
        end
        while (!done && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) begin
            check("done_timeout", 32'(done), 32'd1);
            do_reset();
            req_q.delete();
            exp_q.delete();
            return;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        garbage();
        start = 1'b1;           // ignored: DUT is in DONE
        @(posedge clk); #1;
        start = 1'b0;
        check("done_single", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic reset_checks();
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_done",     32'(done),      32'd0);
        check("rst_misalign", 32'(misalign),  32'd0);
        check("rst_req",      32'(dmem_req),  32'd0);
        check("rst_we",       32'(dmem_we),   32'd0);
        check("rst_load",     load_data,      32'd0);
        check("rst_addr",     dmem_addr,      32'd0);
        check("rst_be",       32'(dmem_be),   32'd0);
        check("rst_wdata",    dmem_wdata,     32'd0);
        check("rst_state",    32'(state_dbg), 32'(IDLE));
    endtask

    // ---------------- monitor ----------------
    bit       in_req = 1'b0;
    bit       have_cur = 1'b0;
    int       rcnt = 0;
    req_exp_t cur;
    logic [32:0] e;

    always @(negedge clk) begin
        if (dmem_req === 1'b1) begin
            if (!in_req) begin
                in_req = 1'b1;
                rcnt   = 0;
                if (req_q.size() == 0) begin
                    have_cur = 1'b0;
                    check("unexpected_req", 32'(dmem_req), 32'd0);
                end else begin
                    have_cur = 1'b1;
                    cur = req_q.pop_front();
                    check("req_addr", dmem_addr, cur.addr);
                    check("req_be", 32'(dmem_be), 32'(cur.be));
                    check("req_we", 32'(dmem_we), 32'(cur.we));
                    if (cur.chk_wdata) check("req_wdata", dmem_wdata, cur.wdata);
                end
            end
            rcnt++;
        end else if (in_req) begin
            in_req = 1'b0;
            if (have_cur) check("req_cycles", 32'(rcnt), 32'(cur.cycles));
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("misalign", 32'(misalign), 32'(e[32]));
                check("load_data", load_data, e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        req_exp_t r;
        rst        = 1'b1;
        start      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        alu_result = 32'h0;
        store_data = 32'h0;
        dmem_rdata = 32'h0;
        dmem_ack   = 1'b0;
        model_ld   = 32'h0;
        do_reset();
        reset_checks();

        // Directed vectors
        do_op(1'b0, 1'b1, F3_LW,  32'h100, 32'hDEADBEEF, $urandom, 2);
        do_op(1'b1, 1'b0, F3_LB,  32'h103, 32'h0, 32'h80FF1234, 0);
        check("lb_vec", load_data, 32'hFFFFFF80);
        do_op(1'b1, 1'b0, F3_LBU, 32'h103, 32'h0, 32'h80FF1234, 1);
        check("lbu_vec", load_data, 32'h00000080);
        do_op(1'b1, 1'b0, F3_LH,  32'h102, 32'h0, 32'h80017FFF, 0);
        check("lh_vec", load_data, 32'hFFFF8001);
        do_op(1'b1, 1'b0, F3_LHU, 32'h102, 32'h0, 32'h80017FFF, 3);
        check("lhu_vec", load_data, 32'h00008001);
        do_op(1'b0, 1'b1, F3_LB,  32'h201, 32'h000000A5, $urandom, 0);
        check("store_keeps_load", load_data, 32'h00008001);
        do_op(1'b1, 1'b0, F3_LW,  32'h102, 32'h0, 32'h12345678, 1);
        do_op(1'b0, 1'b0, F3_LW,  32'h400, 32'h0, 32'h0, 0);
        do_op(1'b1, 1'b1, F3_LH,  32'h402, 32'hCAFEF00D, $urandom, 1);

        // Reset while a load waits for ack
        r.addr = 32'h300; r.be = 4'hF; r.we = 1'b0; r.chk_wdata = 1'b0;
        r.wdata = 32'h0; r.cycles = 8'd3;
        req_q.push_back(r);
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = F3_LW; alu_result = 32'h300;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstreq_req", 32'(dmem_req), 32'd0);
        check("rstreq_busy", 32'(busy), 32'd0);
        check("rstreq_done", 32'(done), 32'd0);
        rst      = 1'b0;
        model_ld = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        reset_checks();

        // Randomized ops
        for (int i = 0; i < 200; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
